// File: rtl/neural_dataset_loader_pkg.sv
// Shared types and constants for the neural processor dataset loader.
// Holds the loader state encoding and the dataset layout arithmetic.
`timescale 1ns/1ps
package neural_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DONE,
    ERROR
  } loader_state_t;

  localparam int unsigned HDR_WORDS = 2;
  localparam int unsigned REC_WORDS = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TOTAL_W   = 12;
  localparam logic [DATA_W-1:0] ONE = 32'h0001_0000;

  // Header plus five-word records, in 12 bits so 255+255 records cannot wrap
  function automatic logic [TOTAL_W-1:0] dataset_words(input logic [7:0] train,
                                                       input logic [7:0] test);
    return TOTAL_W'(HDR_WORDS) +
           TOTAL_W'(REC_WORDS) * (TOTAL_W'(train) + TOTAL_W'(test));
  endfunction

endpackage

// File: rtl/neural_dataset_loader_if.sv
// Byte stream input and RAM write port of the dataset loader.
// The slave side is the loader; the master side sources bytes and sinks writes.
`timescale 1ns/1ps
interface neural_dataset_loader_if #(
  parameter int ADDR_W = 11
) ();
  import neural_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/neural_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// The completed word is presented combinationally with the fourth byte.
`timescale 1ns/1ps
module neural_word_packer
  import neural_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] low_bytes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: low_bytes        <= low_bytes;
      endcase
    end
  end

  // The fourth byte bypasses the register so the write can issue on the next edge
  assign word_valid = byte_valid && (byte_cnt == 2'd3);
  assign word       = {byte_data, low_bytes};

endmodule

// File: rtl/neural_dataset_loader.sv
// Dataset RAM write-side loader: validates the header, writes words sequentially
// from address 0 and holds the processor in reset until the dataset is complete.
`timescale 1ns/1ps
module neural_dataset_loader
  import neural_pkg::*;
#(
  parameter int ADDR_W         = 11,
  parameter int MEM_WORDS      = 2048,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  neural_dataset_loader_if.slave  bus,
  output logic                    proc_rst,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [7:0]              num_train,
  output logic [7:0]              num_test
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] IDLE_LIMIT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  loader_state_t      state_q, state_d;
  logic               accept;
  logic               word_valid;
  logic [DATA_W-1:0]  word;
  logic [CNT_W-1:0]   idle_cnt;
  logic [TOTAL_W-1:0] word_idx;
  logic [TOTAL_W-1:0] total_q;
  logic [TOTAL_W-1:0] total_calc;
  logic               do_write;
  logic               latch_train;
  logic               latch_test;
  logic               restart;
  logic               timeout_hit;
  logic               proc_rst_q;

  assign bus.rx_ready = (state_q == HEADER) || (state_q == PAYLOAD);
  assign busy         = (state_q == HEADER) || (state_q == PAYLOAD);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign proc_rst     = proc_rst_q;
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign total_calc   = dataset_words(num_train, word[7:0]);
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && busy && !accept &&
                        (idle_cnt == IDLE_LIMIT);

  neural_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart || timeout_hit),
    .byte_valid (accept),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Header words are checked before they are written; a rejected word never reaches RAM
  always_comb begin
    state_d     = state_q;
    do_write    = 1'b0;
    latch_train = 1'b0;
    latch_test  = 1'b0;
    restart     = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = HEADER;
          restart = 1'b1;
        end
      end
      HEADER: begin
        if (timeout_hit) begin
          state_d = ERROR;
        end else if (word_valid) begin
          if (word[DATA_W-1:8] != '0) begin
            state_d = ERROR;
          end else if (word_idx == '0) begin
            latch_train = 1'b1;
            do_write    = 1'b1;
          end else begin
            latch_test = 1'b1;
            if (total_calc > TOTAL_W'(MEM_WORDS)) begin
              state_d = ERROR;
            end else begin
              do_write = 1'b1;
              state_d  = (total_calc == TOTAL_W'(HDR_WORDS)) ? DONE : PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (timeout_hit) begin
          state_d = ERROR;
        end else if (word_valid) begin
          do_write = 1'b1;
          if (word_idx == total_q - TOTAL_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // proc_rst drops only on the second DONE cycle so the last write lands first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_rst_q <= 1'b1;
    end else begin
      proc_rst_q <= !((state_q == DONE) && (state_d == DONE));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      word_idx    <= '0;
    end else begin
      bus.wr_en <= do_write;
      if (restart) begin
        word_idx <= '0;
      end else if (do_write) begin
        bus.wr_addr <= word_idx[ADDR_W-1:0];
        bus.wr_data <= word;
        word_idx    <= word_idx + TOTAL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_train <= 8'd0;
      num_test  <= 8'd0;
      total_q   <= '0;
    end else begin
      if (latch_train) begin
        num_train <= word[7:0];
      end
      if (latch_test) begin
        num_test <= word[7:0];
        total_q  <= total_calc;
      end
    end
  end

  // Counts consecutive cycles without an accepted byte while a load is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (restart || accept || !busy) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_neural_dataset_loader.sv
// Self-checking bench for neural_dataset_loader: table of header vectors with random
// payloads checked against a stream-level model, plus timeout and async-reset sequences.
`timescale 1ns/1ps
module tb_neural_dataset_loader;

  localparam int ADDR_W    = 11;
  localparam int MEM_WORDS = 2048;
  localparam int TIMEOUT   = 16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       proc_rst;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] num_train;
  logic [7:0] num_test;

  neural_dataset_loader_if #(.ADDR_W(ADDR_W)) bus ();

  neural_dataset_loader #(
    .ADDR_W         (ADDR_W),
    .MEM_WORDS      (MEM_WORDS),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .proc_rst  (proc_rst),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .num_train (num_train),
    .num_test  (num_test)
  );

  typedef struct {
    int          nt;
    int          ntest;
    logic [23:0] hi0;
    logic [23:0] hi1;
    int          gap;
    int          start_at;
    logic        exp_done;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              done;
    logic              prst;
  } cap_t;

  vec_t       vecs[$];
  logic [7:0] stream[$];
  exp_t       exp_q[$];
  cap_t       cap_q[$];
  int         exp_acc;
  logic       exp_done;
  logic       exp_err;
  logic       post_prst = 1'b1;
  logic       post_pending = 1'b0;
  int         checks = 0;
  int         failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor, plus proc_rst sampled one cycle after a write seen with done high
  always @(negedge clk) begin
    cap_t c;
    if (post_pending) begin
      post_prst    = proc_rst;
      post_pending = 1'b0;
    end
    if (bus.wr_en) begin
      c.addr = bus.wr_addr;
      c.data = bus.wr_data;
      c.done = done;
      c.prst = proc_rst;
      cap_q.push_back(c);
      if (done) post_pending = 1'b1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".rx_ready"},  32'(bus.rx_ready), 32'd0);
    check_output({tag, ".wr_en"},     32'(bus.wr_en),    32'd0);
    check_output({tag, ".wr_addr"},   32'(bus.wr_addr),  32'd0);
    check_output({tag, ".wr_data"},   bus.wr_data,       32'd0);
    check_output({tag, ".proc_rst"},  32'(proc_rst),     32'd1);
    check_output({tag, ".busy"},      32'(busy),         32'd0);
    check_output({tag, ".done"},      32'(done),         32'd0);
    check_output({tag, ".error"},     32'(error),        32'd0);
    check_output({tag, ".num_train"}, 32'(num_train),    32'd0);
    check_output({tag, ".num_test"},  32'(num_test),     32'd0);
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
  endtask

  // Header, random payload sized from the header when it is valid, then 4 surplus bytes
  task automatic build_stream(input vec_t v);
    int total;
    stream.delete();
    push_word({v.hi0, 8'(v.nt)});
    push_word({v.hi1, 8'(v.ntest)});
    total = 2 + 5 * (v.nt + v.ntest);
    if (v.hi0 == 24'h0 && v.hi1 == 24'h0 && total <= MEM_WORDS) begin
      for (int i = 0; i < (total - 2) * 4; i++) stream.push_back(8'($urandom));
    end
    for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
  endtask

  // Reference: which words of the stream reach RAM, and how many bytes are consumed
  task automatic model_stream();
    logic [31:0] w0;
    logic [31:0] w1;
    int          total;
    exp_t        e;
    exp_q.delete();
    exp_acc  = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    w0 = word_at(0);
    if (w0[31:8] != 24'h0) begin
      exp_acc = 4;
      exp_err = 1'b1;
      return;
    end
    e.addr = '0;
    e.data = w0;
    exp_q.push_back(e);
    w1 = word_at(1);
    total = 2 + 5 * (int'(w0[7:0]) + int'(w1[7:0]));
    if (w1[31:8] != 24'h0 || total > MEM_WORDS) begin
      exp_acc = 8;
      exp_err = 1'b1;
      return;
    end
    for (int i = 1; i < total; i++) begin
      e.addr = ADDR_W'(i);
      e.data = word_at(i);
      exp_q.push_back(e);
    end
    exp_acc  = 4 * total;
    exp_done = 1'b1;
  endtask

  // Start pulse with the first byte already valid; it must be taken the next cycle
  task automatic begin_load(input string tag);
    start        = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = stream[0];
    @(posedge clk); #1;
    start = 1'b0;
    check_output({tag, ".ready_after_start"}, 32'(bus.rx_ready), 32'd1);
    check_output({tag, ".busy_after_start"},  32'(busy),         32'd1);
  endtask

  task automatic send_stream(input int max_gap, input int start_at, output int acc);
    int w;
    acc = 0;
    for (int i = 0; i < stream.size(); i++) begin
      if (i > 0 && max_gap > 0) begin
        bus.rx_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) begin
          @(posedge clk); #1;
        end
      end
      bus.rx_data  = stream[i];
      bus.rx_valid = 1'b1;
      if (i == start_at) start = 1'b1;
      w = 0;
      while (!bus.rx_ready && w < 4) begin
        @(posedge clk); #1;
        start = 1'b0;
        w++;
      end
      if (!bus.rx_ready) begin
        bus.rx_valid = 1'b0;
        start        = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      acc++;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    int base;
    int acc;
    int n;
    base = cap_q.size();
    build_stream(v);
    model_stream();
    begin_load(tag);
    send_stream(v.gap, v.start_at, acc);
    repeat (3) @(posedge clk);
    #1;
    n = cap_q.size() - base;
    check_output({tag, ".done"},     32'(done),         32'(v.exp_done));
    check_output({tag, ".error"},    32'(error),        32'(v.exp_err));
    check_output({tag, ".busy"},     32'(busy),         32'd0);
    check_output({tag, ".rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check_output({tag, ".proc_rst"}, 32'(proc_rst),     32'(!v.exp_done));
    check_output({tag, ".writes"},   32'(n),            32'(v.exp_writes));
    check_output({tag, ".accepted"}, 32'(acc),          32'(exp_acc));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n) begin
        check_output($sformatf("%s.wr_addr[%0d]", tag, i), 32'(cap_q[base+i].addr), 32'(exp_q[i].addr));
        check_output($sformatf("%s.wr_data[%0d]", tag, i), cap_q[base+i].data, exp_q[i].data);
      end
    end
    if (v.hi0 == 24'h0) check_output({tag, ".num_train"}, 32'(num_train), 32'(v.nt));
    if (v.hi0 == 24'h0 && v.hi1 == 24'h0) check_output({tag, ".num_test"}, 32'(num_test), 32'(v.ntest));
    if (v.exp_done && n >= 2) begin
      check_output({tag, ".done_on_last_write"}, 32'(cap_q[base+n-1].done), 32'd1);
      check_output({tag, ".prst_on_last_write"}, 32'(cap_q[base+n-1].prst), 32'd1);
      check_output({tag, ".done_before_last"},   32'(cap_q[base+n-2].done), 32'd0);
      check_output({tag, ".prst_after_last"},    32'(post_prst),            32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   acc;
    int   base;
    logic early_err;
    vec_t v;

    vecs.push_back('{0,   0,   24'h1, 24'h0, 0, -1, 1'b0, 1'b1, 0});
    vecs.push_back('{1,   1,   24'h0, 24'h0, 0, -1, 1'b1, 1'b0, 12});
    vecs.push_back('{0,   0,   24'h0, 24'h0, 1, -1, 1'b1, 1'b0, 2});
    vecs.push_back('{255, 255, 24'h0, 24'h0, 1, -1, 1'b0, 1'b1, 1});
    vecs.push_back('{2,   1,   24'h0, 24'h0, 3, 20, 1'b1, 1'b0, 17});
    vecs.push_back('{3,   1,   24'h0, 24'h2, 1, -1, 1'b0, 1'b1, 1});
    vecs.push_back('{0,   3,   24'h0, 24'h0, 2, -1, 1'b1, 1'b0, 17});
    vecs.push_back('{255, 154, 24'h0, 24'h0, 0, -1, 1'b1, 1'b0, 2047});
    vecs.push_back('{255, 155, 24'h0, 24'h0, 0, -1, 1'b0, 1'b1, 1});
    vecs.push_back('{1,   1,   24'h0, 24'h0, 2, -1, 1'b1, 1'b0, 12});
    vecs.push_back('{0,   2,   24'h0, 24'h0, 3, -1, 1'b1, 1'b0, 12});

    rst_n        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #3 rst_n = 1'b0;
    #1 check_reset_values("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("idle.rx_ready", 32'(bus.rx_ready), 32'd0);
    check_output("idle.proc_rst", 32'(proc_rst),     32'd1);

    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Timeout: two payload bytes then silence; error must appear on the 16th idle cycle
    base = cap_q.size();
    stream.delete();
    push_word(32'd1);
    push_word(32'd1);
    stream.push_back(8'($urandom));
    stream.push_back(8'($urandom));
    begin_load("timeout");
    send_stream(0, -1, acc);
    check_output("timeout.accepted", 32'(acc), 32'd10);
    early_err = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (i < TIMEOUT) early_err = early_err | error;
    end
    check_output("timeout.no_early_error", 32'(early_err), 32'd0);
    check_output("timeout.error",          32'(error),     32'd1);
    check_output("timeout.rx_ready",       32'(bus.rx_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("timeout.writes", 32'(cap_q.size() - base), 32'd2);

    apply_stimulus(vecs[9], "after_timeout");

    // Asynchronous reset in the middle of a payload word, then a clean reload
    v = vecs[4];
    build_stream(v);
    stream = stream[0:25];
    begin_load("midrst");
    send_stream(2, -1, acc);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(vecs[10], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
